// File: rtl/lab0_pkg.sv
// rtl/lab0_pkg.sv - shared op encodings, FSM states and ALU helper for lab0_op_controller
package lab0_pkg;

   localparam logic [1:0] OP_AND = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   localparam logic [1:0] OP_ADD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // Returns {carry, result}; carry is only ever set by ADD.
   function automatic logic [4:0] op_compute(input logic [1:0] op,
                                              input logic [3:0] a,
                                              input logic [3:0] b);
      logic [4:0] r;
      case (op)
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         default: r = {1'b0, a} + {1'b0, b};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchronizer, counter debounce and rising-edge press pulse
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic press
);

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic        sync1_q, sync2_q;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic [15:0] cnt_q, cnt_d;

   // The count only survives while the synchronized input keeps disagreeing with the level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/lab0_op_controller.sv
// rtl/lab0_op_controller.sv - two-button operation selector and 4-bit ALU executor
module lab0_op_controller
   import lab0_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left_pushbutton,
   input  logic       right_pushbutton,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [1:0] op_sel,
   output logic [3:0] result,
   output logic       carry_out,
   output logic       result_valid,
   output logic       busy
);

   logic left_press, right_press;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left_db (
      .clk    (clk),
      .rst    (rst),
      .btn_in (left_pushbutton),
      .press  (left_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right_db (
      .clk    (clk),
      .rst    (rst),
      .btn_in (right_pushbutton),
      .press  (right_press)
   );

   state_e     state_q, state_d;
   logic [1:0] op_sel_q, op_sel_d;
   logic [1:0] op_q, op_d;
   logic [3:0] a_q, a_d, b_q, b_d;
   logic [3:0] result_q, result_d;
   logic       carry_q, carry_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      op_sel_d = op_sel_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      case (state_q)
         // Presses outside IDLE fall through untouched, so they are dropped.
         ST_IDLE: begin
            if (right_press) begin
               state_d = ST_CAPTURE;
            end else if (left_press) begin
               op_sel_d = op_sel_q + 2'd1;
            end
         end
         ST_CAPTURE: begin
            a_d     = A;
            b_d     = B;
            op_d    = op_sel_q;
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            {carry_d, result_d} = op_compute(op_q, a_q, b_q);
            state_d             = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d  = (state_d != ST_IDLE);
      valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_sel_q <= OP_AND;
         op_q     <= OP_AND;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_sel_q <= op_sel_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign op_sel       = op_sel_q;
   assign result       = result_q;
   assign carry_out    = carry_q;
   assign result_valid = valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_lab0_op_controller.sv
// tb/tb_lab0_op_controller.sv - scoreboard bench for lab0_op_controller
module tb_lab0_op_controller;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       left_pushbutton, right_pushbutton;
   logic [3:0] A, B;
   logic [1:0] op_sel;
   logic [3:0] result;
   logic       carry_out, result_valid, busy;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         valid_count = 0;
   logic [4:0] exp_q[$];

   lab0_op_controller #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk              (clk),
      .rst              (rst),
      .left_pushbutton  (left_pushbutton),
      .right_pushbutton (right_pushbutton),
      .A                (A),
      .B                (B),
      .op_sel           (op_sel),
      .result           (result),
      .carry_out        (carry_out),
      .result_valid     (result_valid),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // Scoreboard: every result_valid pulse must match the oldest pushed {carry, result}.
   always @(negedge clk) begin
      if (!rst && result_valid === 1'b1) begin
         logic [4:0] e;
         valid_count++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_result_valid: got result=%b carry=%b, required no pulse", result, carry_out);
         end else begin
            e = exp_q.pop_front();
            if ({carry_out, result} !== e) begin
               n_fail++;
               $display("FAIL scoreboard_result: got carry=%b result=%b, required carry=%b result=%b",
                        carry_out, result, e[4], e[3:0]);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clean_press(input bit is_right);
      if (is_right) right_pushbutton = 1'b1; else left_pushbutton = 1'b1;
      tick(DB + 8);
      if (is_right) right_pushbutton = 1'b0; else left_pushbutton = 1'b0;
      tick(DB + 8);
   endtask

   task automatic wait_busy(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (busy === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_busy_timeout: got busy=%b, required 1 within 40 cycles", name, busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      left_pushbutton = 1'b0;
      right_pushbutton = 1'b0;
      A = 4'b0000;
      B = 4'b0000;
      tick(3);
      n_checks++;
      if ({op_sel, result, carry_out, result_valid, busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got op=%b res=%b c=%b v=%b busy=%b, required all 0",
                  op_sel, result, carry_out, result_valid, busy);
      end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_and;
      int busy_cycles = 0;
      int v0 = valid_count;
      A = 4'b1100;
      B = 4'b1010;
      n_checks++;
      if (op_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL and_op_sel: got %0d, required 0", op_sel);
      end
      exp_q.push_back({1'b0, 4'b1000});
      right_pushbutton = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (busy === 1'b1) busy_cycles++;
      end
      right_pushbutton = 1'b0;
      tick(DB + 8);
      n_checks++;
      if (busy_cycles != 3) begin
         n_fail++;
         $display("FAIL and_busy_cycles: got %0d, required 3", busy_cycles);
      end
      n_checks++;
      if (valid_count - v0 != 1) begin
         n_fail++;
         $display("FAIL and_valid_pulses: got %0d, required 1", valid_count - v0);
      end
      n_checks++;
      if ({carry_out, result} !== 5'b01000) begin
         n_fail++;
         $display("FAIL and_result_hold: got c=%b res=%b, required c=0 res=1000", carry_out, result);
      end
   endtask

   task automatic test_reset_mid_execute;
      int v0;
      clean_press(1'b0);
      A = 4'b1100;
      B = 4'b1010;
      right_pushbutton = 1'b1;
      wait_busy("rstmid");
      tick();
      rst = 1'b1;
      right_pushbutton = 1'b0;
      #1;
      n_checks++;
      if ({op_sel, result, carry_out, result_valid, busy} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_mid_execute: got op=%b res=%b c=%b v=%b busy=%b, required all 0",
                  op_sel, result, carry_out, result_valid, busy);
      end
      v0 = valid_count;
      tick(3);
      rst = 1'b0;
      tick(20);
      n_checks++;
      if (valid_count != v0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_valid_after: got pulses=%0d busy=%b, required 0 and 0", valid_count - v0, busy);
      end
   endtask

   task automatic test_cycling;
      logic [4:0] exp_tbl [1:3];
      exp_tbl[1] = {1'b0, 4'b1110};
      exp_tbl[2] = {1'b0, 4'b0110};
      exp_tbl[3] = {1'b1, 4'b0110};
      A = 4'b1100;
      B = 4'b1010;
      for (int k = 1; k <= 3; k++) begin
         clean_press(1'b0);
         n_checks++;
         if (op_sel !== 2'(k)) begin
            n_fail++;
            $display("FAIL cycle_op_sel_%0d: got %0d, required %0d", k, op_sel, k);
         end
         exp_q.push_back(exp_tbl[k]);
         clean_press(1'b1);
      end
      clean_press(1'b0);
      n_checks++;
      if (op_sel !== 2'd0) begin
         n_fail++;
         $display("FAIL cycle_wrap: got %0d, required 0", op_sel);
      end
   endtask

   task automatic test_bounce;
      int v0 = valid_count;
      A = 4'b1100;
      B = 4'b1010;
      exp_q.push_back({1'b0, 4'b1000});
      for (int i = 0; i < 10; i++) begin
         right_pushbutton = (i % 2 == 0);
         tick();
      end
      right_pushbutton = 1'b1;
      tick(20);
      right_pushbutton = 1'b0;
      tick(DB + 8);
      n_checks++;
      if (valid_count - v0 != 1) begin
         n_fail++;
         $display("FAIL bounce_single_exec: got %0d executions, required 1", valid_count - v0);
      end
      v0 = valid_count;
      right_pushbutton = 1'b1;
      tick(3);
      right_pushbutton = 1'b0;
      tick(20);
      n_checks++;
      if (valid_count != v0) begin
         n_fail++;
         $display("FAIL short_pulse_rejected: got %0d executions, required 0", valid_count - v0);
      end
   endtask

   task automatic test_isolation;
      clean_press(1'b0);
      clean_press(1'b0);
      clean_press(1'b0);
      n_checks++;
      if (op_sel !== 2'd3) begin
         n_fail++;
         $display("FAIL iso_setup_op_sel: got %0d, required 3", op_sel);
      end
      A = 4'b1100;
      B = 4'b1010;
      exp_q.push_back({1'b1, 4'b0110});
      right_pushbutton = 1'b1;
      tick();
      left_pushbutton = 1'b1;
      wait_busy("iso");
      tick();
      A = 4'b0000;
      tick(20);
      right_pushbutton = 1'b0;
      left_pushbutton = 1'b0;
      tick(DB + 8);
      n_checks++;
      if (op_sel !== 2'd3) begin
         n_fail++;
         $display("FAIL iso_left_dropped: got op_sel=%0d, required 3", op_sel);
      end
   endtask

   task automatic test_simultaneous;
      int v0;
      clean_press(1'b0);
      clean_press(1'b0);
      clean_press(1'b0);
      n_checks++;
      if (op_sel !== 2'd2) begin
         n_fail++;
         $display("FAIL simul_setup_op_sel: got %0d, required 2", op_sel);
      end
      v0 = valid_count;
      A = 4'b1100;
      B = 4'b1010;
      exp_q.push_back({1'b0, 4'b0110});
      left_pushbutton = 1'b1;
      right_pushbutton = 1'b1;
      tick(20);
      left_pushbutton = 1'b0;
      right_pushbutton = 1'b0;
      tick(DB + 8);
      n_checks++;
      if (op_sel !== 2'd2 || valid_count - v0 != 1) begin
         n_fail++;
         $display("FAIL simul_right_priority: got op_sel=%0d execs=%0d, required 2 and 1",
                  op_sel, valid_count - v0);
      end
   endtask

   initial begin
      test_reset();
      test_and();
      test_reset_mid_execute();
      test_cycling();
      test_bounce();
      test_isolation();
      test_simultaneous();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
